// File: rtl/planar_tile_rx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// planar_tile_rx_if : beat input and planar tile output handshakes
// Revision 1.0
// ---------------------------------------------------------------------------
interface planar_tile_rx_if #(
  parameter int TILE_W = 2048
);
  logic [1:0]        i_beat_mode;
  logic              i_abort;
  logic              i_valid;
  logic              o_ready;
  logic [511:0]      i_data;
  logic [TILE_W-1:0] o_plane;
  logic              o_valid;
  logic              i_ready;

  modport slave (
    input  i_beat_mode, i_abort, i_valid, i_data, i_ready,
    output o_ready, o_plane, o_valid
  );

  modport master (
    output i_beat_mode, i_abort, i_valid, i_data, i_ready,
    input  o_ready, o_plane, o_valid
  );
endinterface
`default_nettype wire

// File: rtl/planar_tile_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// planar_tile_rx : interleaved pixel beats -> ping-pong planar tiles
// Optional statistics outputs under `PLANAR_TILE_RX_STATS_EN. Revision 1.0
// ---------------------------------------------------------------------------
module planar_tile_rx #(
  parameter int TILE_SIZE = 8,
  parameter int CH_NUM    = 4,
  parameter int PIX_BITS  = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  planar_tile_rx_if.slave  bus
`ifdef PLANAR_TILE_RX_STATS_EN
  ,
  output logic [15:0]      o_tile_cnt,
  output logic [7:0]       o_abort_cnt
`endif
);
  localparam int NPIX    = TILE_SIZE * TILE_SIZE;
  localparam int PIX_W   = CH_NUM * PIX_BITS;
  localparam int PLANE_W = NPIX * PIX_BITS;
  localparam int TILE_W  = CH_NUM * PLANE_W;
  localparam int PPB0    = 128 / PIX_W;
  localparam int PPB1    = 256 / PIX_W;
  localparam int PPB2    = 512 / PIX_W;
  localparam int BPT0    = NPIX / PPB0;
  localparam int BPT1    = NPIX / PPB1;
  localparam int BPT2    = NPIX / PPB2;
  localparam int CW      = $clog2(BPT0);

  logic [1:0]        r_mode;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_full;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [TILE_W-1:0] r_bank [2];

  logic [1:0]        w_mode;
  logic              w_m0, w_m1, w_m2;
  logic              w_last, w_take, w_acc, w_rel;
  logic [NPIX-1:0]   w_we;
  logic [PIX_W-1:0]  w_pix [NPIX];

  // The first beat of a tile uses the live mode; later beats use the latched one.
  assign w_mode = (r_cnt == '0) ? bus.i_beat_mode : r_mode;
  assign w_m0   = (w_mode == 2'd0);
  assign w_m1   = (w_mode == 2'd1);
  assign w_m2   = w_mode[1];

  assign w_last = w_m0 ? (r_cnt == CW'(BPT0 - 1)) :
                  w_m1 ? (r_cnt == CW'(BPT1 - 1)) :
                         (r_cnt == CW'(BPT2 - 1));

  assign w_take = bus.i_valid & bus.o_ready;
  assign w_acc  = w_take & ~bus.i_abort;
  assign w_rel  = bus.o_valid & bus.i_ready;

  assign bus.o_ready = ~r_full[r_wr_sel];
  assign bus.o_valid = r_full[r_rd_sel];
  assign bus.o_plane = r_bank[r_rd_sel];

  // Each tile pixel has a fixed source beat and lane per mode.
  for (genvar n = 0; n < NPIX; n++) begin : g_pix
    localparam logic [CW-1:0] K0 = CW'(n / PPB0);
    localparam logic [CW-1:0] K1 = CW'(n / PPB1);
    localparam logic [CW-1:0] K2 = CW'(n / PPB2);
    localparam int P0 = n % PPB0;
    localparam int P1 = n % PPB1;
    localparam int P2 = n % PPB2;

    assign w_we[n]  = w_acc & ((w_m0 & (r_cnt == K0)) |
                               (w_m1 & (r_cnt == K1)) |
                               (w_m2 & (r_cnt == K2)));
    assign w_pix[n] = w_m0 ? bus.i_data[P0*PIX_W +: PIX_W] :
                      w_m1 ? bus.i_data[P1*PIX_W +: PIX_W] :
                             bus.i_data[P2*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= 2'd0;
      r_cnt    <= '0;
      r_full   <= 2'b00;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_bank[0] <= '0;
      r_bank[1] <= '0;
    end else begin
      // Release and completion always target different banks.
      if (w_rel) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= ~r_rd_sel;
      end
      if (bus.i_abort) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        if (r_cnt == '0) begin
          r_mode <= bus.i_beat_mode;
        end
        if (w_last) begin
          r_cnt            <= '0;
          r_full[r_wr_sel] <= 1'b1;
          r_wr_sel         <= ~r_wr_sel;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      for (int n = 0; n < NPIX; n++) begin
        if (w_we[n]) begin
          for (int c = 0; c < CH_NUM; c++) begin
            r_bank[r_wr_sel][c*PLANE_W + n*PIX_BITS +: PIX_BITS] <=
                w_pix[n][c*PIX_BITS +: PIX_BITS];
          end
        end
      end
    end
  end

`ifdef PLANAR_TILE_RX_STATS_EN
  logic [15:0] r_tile_cnt;
  logic [7:0]  r_abort_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tile_cnt  <= 16'd0;
      r_abort_cnt <= 8'd0;
    end else begin
      if (w_rel) begin
        r_tile_cnt <= r_tile_cnt + 16'd1;
      end
      // An abort counts when it throws away stored beats or the beat offered with it.
      if (bus.i_abort && ((r_cnt != '0) || w_take) && (r_abort_cnt != 8'hFF)) begin
        r_abort_cnt <= r_abort_cnt + 8'd1;
      end
    end
  end

  assign o_tile_cnt  = r_tile_cnt;
  assign o_abort_cnt = r_abort_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_planar_tile_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_planar_tile_rx : randomized and directed bench with a tile-queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_planar_tile_rx;
  localparam int TILE_SIZE = 8;
  localparam int CH_NUM    = 4;
  localparam int PIX_BITS  = 8;
  localparam int NPIX      = TILE_SIZE * TILE_SIZE;
  localparam int PIX_W     = CH_NUM * PIX_BITS;
  localparam int PLANE_W   = NPIX * PIX_BITS;
  localparam int TILE_W    = CH_NUM * PLANE_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  planar_tile_rx_if #(.TILE_W(TILE_W)) bus ();

`ifdef PLANAR_TILE_RX_STATS_EN
  logic [15:0] tile_cnt;
  logic [7:0]  abort_cnt;
`endif

  planar_tile_rx #(
    .TILE_SIZE(TILE_SIZE),
    .CH_NUM   (CH_NUM),
    .PIX_BITS (PIX_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PLANAR_TILE_RX_STATS_EN
    ,
    .o_tile_cnt (tile_cnt),
    .o_abort_cnt(abort_cnt)
`endif
  );

  // Reference: completed tiles waiting for the consumer, plus pixels of the tile in flight.
  logic [TILE_W-1:0] tq [$];
  logic [PIX_W-1:0]  pix_q [$];
  logic [1:0]        lat_mode;
  int m_tiles, m_aborts, pulses;
  int n_checks, n_errs;

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ppb_of(logic [1:0] m);
    return ((m == 2'd0) ? 128 : (m == 2'd1) ? 256 : 512) / PIX_W;
  endfunction

  task automatic set_in(bit v, logic [511:0] d, logic [1:0] m, bit ab, bit rd);
    bus.i_valid     = v;
    bus.i_data      = d;
    bus.i_beat_mode = m;
    bus.i_abort     = ab;
    bus.i_ready     = rd;
  endtask

  task automatic tick();
    bit er, ev, take, rel;
    logic [TILE_W-1:0] t;
    er = (tq.size() < 2);
    ev = (tq.size() > 0);
    check("o_ready", bus.o_ready, er);
    check("o_valid", bus.o_valid, ev);
    if (ev) begin
      for (int c = 0; c < CH_NUM; c++)
        check($sformatf("plane%0d", c), bus.o_plane[c*PLANE_W +: PLANE_W], tq[0][c*PLANE_W +: PLANE_W]);
    end
    take = bus.i_valid && er;
    rel  = ev && bus.i_ready;
    @(posedge clk);
    if (rel) begin
      void'(tq.pop_front());
      m_tiles++;
      pulses++;
    end
    if (bus.i_abort) begin
      if ((pix_q.size() > 0 || take) && m_aborts < 255) m_aborts++;
      pix_q.delete();
    end else if (take) begin
      if (pix_q.size() == 0) lat_mode = bus.i_beat_mode;
      for (int p = 0; p < ppb_of(lat_mode); p++) pix_q.push_back(bus.i_data[p*PIX_W +: PIX_W]);
      if (pix_q.size() == NPIX) begin
        t = '0;
        for (int n = 0; n < NPIX; n++)
          for (int c = 0; c < CH_NUM; c++)
            t[c*PLANE_W + n*PIX_BITS +: PIX_BITS] = pix_q[n][c*PIX_BITS +: PIX_BITS];
        tq.push_back(t);
        pix_q.delete();
      end
    end
    #1;
  endtask

  task automatic send_beat(logic [511:0] d, logic [1:0] m, bit rd);
    bit ok;
    set_in(1'b1, d, m, 1'b0, rd);
    for (int i = 0; i < 64; i++) begin
      ok = (tq.size() < 2);
      tick();
      if (ok) begin
        bus.i_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 1, 0);
    bus.i_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_valid", bus.o_valid, 0);
    check("rst_ready", bus.o_ready, 1);
    check("rst_plane", bus.o_plane[511:0], 0);
    tq.delete();
    pix_q.delete();
    set_in(1'b0, '0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pat0(int k);
    logic [511:0] d;
    int n;
    d = '0;
    for (int p = 0; p < 4; p++) begin
      n = k * 4 + p;
      d[p*32 +: 32] = 32'hA000_0000 | (n << 16) | (n << 8) | n;
    end
    return d;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] d55;
    n_checks = 0; n_errs = 0; m_tiles = 0; m_aborts = 0; pulses = 0; lat_mode = 2'd0;
    set_in(1'b0, '0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #3;
    do_reset();

    // Mode 0 pattern tile, consumer ready.
    for (int k = 0; k < 16; k++) send_beat(pat0(k), 2'd0, 1'b1);
    check("t1_valid", bus.o_valid, 1);
    check("t1_B5", bus.o_plane[0*PLANE_W + 5*8 +: 8], 8'd5);
    check("t1_G9", bus.o_plane[1*PLANE_W + 9*8 +: 8], 8'd9);
    check("t1_R63", bus.o_plane[2*PLANE_W + 63*8 +: 8], 8'd63);
    check("t1_A0", bus.o_plane[3*PLANE_W + 0*8 +: 8], 8'hA0);
    set_in(1'b0, '0, 2'd0, 1'b0, 1'b1);
    tick();
    tick();

    // Mode 2, three tiles with consumer stalled; one-cycle release unblocks tile 3.
    for (int k = 0; k < 8; k++) send_beat(rnd512(), 2'd2, 1'b0);
    check("both_full_ready", bus.o_ready, 0);
    set_in(1'b1, rnd512(), 2'd2, 1'b0, 1'b0);
    tick();
    tick();
    bus.i_ready = 1'b1;
    tick();
    check("rel_ready", bus.o_ready, 1);
    bus.i_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_beat(rnd512(), 2'd2, 1'b0);
    set_in(1'b0, '0, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // Mid-tile mode change is ignored; next tile uses the new mode.
    for (int k = 0; k < 3; k++) send_beat(rnd512(), 2'd1, 1'b0);
    for (int k = 0; k < 5; k++) send_beat(rnd512(), 2'd0, 1'b0);
    check("latch_valid", bus.o_valid, 1);
    for (int k = 0; k < 16; k++) send_beat(rnd512(), 2'd0, 1'b0);
    set_in(1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // Abort after two beats, then a full 0x55 tile.
    pulses = 0;
    for (int k = 0; k < 2; k++) send_beat(rnd512(), 2'd2, 1'b1);
    set_in(1'b0, '0, 2'd2, 1'b1, 1'b1);
    tick();
    d55 = {64{8'h55}};
    for (int k = 0; k < 4; k++) send_beat(d55, 2'd2, 1'b1);
    check("abort_plane0", bus.o_plane[0*PLANE_W +: PLANE_W], d55);
    check("abort_plane3", bus.o_plane[3*PLANE_W +: PLANE_W], d55);
    set_in(1'b0, '0, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("abort_pulses", pulses, 1);

    // Reset during beat 5 of a mode 0 tile with one bank pending.
    for (int k = 0; k < 16; k++) send_beat(rnd512(), 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) send_beat(rnd512(), 2'd0, 1'b0);
    set_in(1'b1, rnd512(), 2'd0, 1'b0, 1'b0);
    do_reset();
`ifdef PLANAR_TILE_RX_STATS_EN
    m_tiles = 0; m_aborts = 0;
`endif
    for (int k = 0; k < 16; k++) send_beat(pat0(k), 2'd0, 1'b1);
    set_in(1'b0, '0, 2'd0, 1'b0, 1'b1);
    tick();
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 9) < 7), rnd512(), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < 3), $urandom_range(0, 1) == 1);
      tick();
    end
    set_in(1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();

`ifdef PLANAR_TILE_RX_STATS_EN
    for (int i = 0; i < 300; i++) begin
      send_beat(rnd512(), 2'd2, 1'b1);
      set_in(1'b0, '0, 2'd2, 1'b1, 1'b1);
      tick();
    end
    set_in(1'b0, '0, 2'd0, 1'b0, 1'b1);
    tick();
    check("abort_cnt", abort_cnt, 8'hFF);
    check("tile_cnt", tile_cnt, 16'(m_tiles));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
`default_nettype wire
